// File: rtl/uart_axi_lite.sv
// uart_axi_lite: AXI4-Lite slave UART (8N1) with RX/TX byte FIFOs.
// Define UART_LOOPBACK_EN to feed the receiver from the internal txd instead of rxd.
module uart_axi_lite #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [3:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic        rxd,
  output logic        txd
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  r_state_t r_q, r_d;
  w_state_t w_q, w_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0] rresp_q, rresp_d, bresp_q, bresp_d;
  logic rpop_q, rpop_d, tx_push, tx_pop, rx_push, rx_pop;
  logic [1:0] push, pop, empty, full;
  logic [1:0][7:0] din, head;
  logic [1:0][AW:0] cnt;
  logic tx_busy_q, tx_busy_d, rx_busy_q, rx_busy_d, rx_prev_q, rx_s, rx_in, unused_ok;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [3:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [2:0] tx_idx;
  logic [1:0] rx_sync_q;
  logic [7:0] rx_sh_q, rx_sh_d;
  // FIFO 0 holds received bytes, FIFO 1 holds bytes waiting to be sent
  assign push = {tx_push, rx_push};
  assign pop = {tx_pop, rx_pop};
  assign din = {s_axi_wdata[7:0], rx_sh_q};
  for (genvar f = 0; f < 2; f++) begin : g_fifo
    logic [7:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wp_q, wp_d, rp_q, rp_d;
    assign empty[f] = wp_q == rp_q;
    assign full[f] = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign cnt[f] = wp_q - rp_q;
    assign head[f] = mem_q[rp_q[AW-1:0]];
    always_comb begin
      wp_d = (push[f] && !full[f]) ? wp_q + 1'b1 : wp_q;
      rp_d = (pop[f] && !empty[f]) ? rp_q + 1'b1 : rp_q;
    end
    always_ff @(posedge clk) begin
      wp_q <= rst ? '0 : wp_d;
      rp_q <= rst ? '0 : rp_d;
      if (push[f] && !full[f]) mem_q[wp_q[AW-1:0]] <= din[f];
    end
  end
  assign s_axi_arready = r_q == R_IDLE;
  assign s_axi_rvalid = r_q == R_RESP;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_awready = w_q == W_IDLE;
  assign s_axi_wready = w_q == W_IDLE;
  assign s_axi_bvalid = w_q == W_RESP;
  assign s_axi_bresp = bresp_q;
  assign rx_pop = r_q == R_RESP && s_axi_rready && rpop_q;
  // Read response is captured when the address is taken; the RX pop waits for the R handshake
  always_comb begin
    r_d = r_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    rpop_d = rpop_q;
    if (r_q == R_IDLE) begin
      if (s_axi_arvalid) begin
        r_d = R_RESP;
        rpop_d = s_axi_araddr == 4'h0 && !empty[0];
        rdata_d = rpop_d ? {24'h0, head[0]} :
                  s_axi_araddr == 4'h8 ? {28'h0, full[1], empty[1], full[0], !empty[0]} : 32'h0;
        rresp_d = (rpop_d || s_axi_araddr == 4'h8) ? 2'b00 : 2'b10;
      end
    end else if (s_axi_rready) r_d = R_IDLE;
  end
  always_comb begin
    w_d = w_q;
    bresp_d = bresp_q;
    tx_push = 1'b0;
    if (w_q == W_IDLE) begin
      if (s_axi_awvalid && s_axi_wvalid) begin
        w_d = W_RESP;
        tx_push = s_axi_awaddr == 4'h4 && !full[1];
        bresp_d = tx_push ? 2'b00 : 2'b10;
      end
    end else if (s_axi_bready) w_d = W_IDLE;
  end
  // The frame is sent straight from the FIFO head, which is only popped after its stop bit
  assign tx_idx = 3'(tx_bit_q - 4'd1);
  assign txd = !tx_busy_q || tx_bit_q == 4'd9 || (tx_bit_q != 4'd0 && head[1][tx_idx]);
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_cnt_d = tx_cnt_q;
    tx_bit_d = tx_bit_q;
    tx_pop = 1'b0;
    if (!tx_busy_q) begin
      tx_busy_d = !empty[1];
      tx_cnt_d = '0;
      tx_bit_d = '0;
    end else if (tx_cnt_q != LAST) tx_cnt_d = tx_cnt_q + 1'b1;
    else begin
      tx_cnt_d = '0;
      tx_pop = tx_bit_q == 4'd9;
      tx_bit_d = tx_pop ? 4'd0 : tx_bit_q + 4'd1;
      tx_busy_d = !tx_pop || |cnt[1][AW:1];
    end
  end
`ifdef UART_LOOPBACK_EN
  assign rx_in = txd;
`else
  assign rx_in = rxd;
`endif
  assign rx_s = rx_sync_q[1];
  // Start bit is rechecked half a bit after the edge; later samples land mid-bit
  always_comb begin
    rx_busy_d = rx_busy_q;
    rx_cnt_d = rx_cnt_q + 1'b1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_push = 1'b0;
    if (!rx_busy_q) begin
      rx_busy_d = rx_prev_q && !rx_s;
      rx_cnt_d = '0;
      rx_bit_d = '0;
    end else if (rx_cnt_q == (rx_bit_q == 4'd0 ? HALF : LAST)) begin
      rx_cnt_d = '0;
      rx_bit_d = rx_bit_q + 4'd1;
      if (rx_bit_q == 4'd0) rx_busy_d = !rx_s;
      else if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rx_push = rx_s && !full[0];
      end else rx_sh_d = {rx_s, rx_sh_q[7:1]};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= R_IDLE;
      w_q <= W_IDLE;
      rdata_q <= '0;
      rresp_q <= '0;
      bresp_q <= '0;
      rpop_q <= 1'b0;
      tx_busy_q <= 1'b0;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
      rx_busy_q <= 1'b0;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
    end else begin
      r_q <= r_d;
      w_q <= w_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
      rpop_q <= rpop_d;
      tx_busy_q <= tx_busy_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_sync_q <= {rx_sync_q[0], rx_in};
      rx_prev_q <= rx_s;
      rx_busy_q <= rx_busy_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
    end
  end
  assign unused_ok = ^{s_axi_wstrb, s_axi_wdata[31:8], rxd, cnt[0]};
endmodule

// File: tb/tb_uart_axi_lite.sv
// tb_uart_axi_lite: randomized AXI and serial stimulus checked against a queue-based UART model.
`timescale 1ns/1ps
module tb_uart_axi_lite;
  localparam int C = 16;
  localparam int D = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] araddr = '0, awaddr = '0, wstrb = 4'hF;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, rxd = 1'b1;
  logic [31:0] wdata = '0;
  logic arready, rvalid, awready, wready, bvalid, txd;
  logic [31:0] rdata;
  logic [1:0] rresp, bresp;
  int n_chk = 0, n_err = 0;
  byte unsigned tx_q[$], rx_q[$];
  logic [31:0] exp_rdata = '0;
  logic [1:0] exp_rresp = '0, exp_bresp = '0;
  bit r_pend = 1'b0, b_pend = 1'b0, m_act = 1'b0;
  logic m_prev = 1'b1;
  int m_t = 0;
  logic [9:0] m_frame = '0, m_cur = '0;

  always #5 clk = ~clk;

  uart_axi_lite #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .rxd(rxd), .txd(txd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: AXI responses against pending expectations, txd against the model's byte
  always @(negedge clk) begin
    if (rst) m_act = 1'b0;
    else begin
      if (!r_pend) chk("rvalid_idle", rvalid, 1'b0);
      else if (rvalid) begin
        chk("rdata", rdata, exp_rdata);
        chk("rresp", rresp, exp_rresp);
      end
      if (!b_pend) chk("bvalid_idle", bvalid, 1'b0);
      else if (bvalid) chk("bresp", bresp, exp_bresp);
      if (!m_act && m_prev && !txd) begin
        chk("tx_frame_expected", 32'(tx_q.size() != 0), 1);
        m_act = tx_q.size() != 0;
        m_t = 0;
        if (m_act) m_cur = {1'b1, tx_q[0], 1'b0};
      end
      if (m_act) begin
        chk("txd_bit", txd, m_cur[m_t / C]);
        if (m_t % C == C / 2) m_frame[m_t / C] = txd;
        if (m_t == 10 * C - 1) begin
`ifdef UART_LOOPBACK_EN
          if (rx_q.size() < D) rx_q.push_back(tx_q[0]);
`endif
          void'(tx_q.pop_front());
          m_act = 1'b0;
        end
        m_t++;
      end
    end
    m_prev = txd;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tx_q.delete();
    rx_q.delete();
    {arvalid, awvalid, wvalid, rready, bready, r_pend, b_pend} = '0;
    rxd = 1'b1;
    @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_txd", txd, 1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input int lead, input int bdly,
                           output logic [1:0] resp);
    int i;
    @(negedge clk);
    awaddr = a;
    wdata = d;
    awvalid = 1'b1;
    repeat (lead) @(negedge clk);
    exp_bresp = (a == 4'h4 && tx_q.size() < D) ? 2'b00 : 2'b10;
    if (exp_bresp == 2'b00) tx_q.push_back(d[7:0]);
    wvalid = 1'b1;
    b_pend = 1'b1;
    i = 0;
    while (!(awready && wready) && i < 100) begin @(negedge clk); i++; end
    chk("aw_w_ready", awready && wready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    repeat (bdly) @(negedge clk);
    bready = 1'b1;
    i = 0;
    while (!bvalid && i < 100) begin @(negedge clk); i++; end
    chk("bvalid_seen", bvalid, 1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
    b_pend = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int i;
    @(negedge clk);
    if (a == 4'h0 && rx_q.size() != 0) begin
      exp_rdata = 32'(rx_q.pop_front());
      exp_rresp = 2'b00;
    end else if (a == 4'h8) begin
      exp_rdata = {28'h0, tx_q.size() == D, tx_q.size() == 0, rx_q.size() == D, rx_q.size() != 0};
      exp_rresp = 2'b00;
    end else begin
      exp_rdata = 32'h0;
      exp_rresp = 2'b10;
    end
    araddr = a;
    arvalid = 1'b1;
    r_pend = 1'b1;
    i = 0;
    while (!arready && i < 100) begin @(negedge clk); i++; end
    chk("arready_seen", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rready = 1'b1;
    i = 0;
    while (!rvalid && i < 100) begin @(negedge clk); i++; end
    chk("rvalid_seen", rvalid, 1);
    d = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
    r_pend = 1'b0;
  endtask

  task automatic send_rx(input byte unsigned b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd = f[k];
      repeat (C) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    if (stop_ok && rx_q.size() < D) rx_q.push_back(b);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while ((tx_q.size() != 0 || m_act) && i < 40000) begin @(negedge clk); i++; end
    chk("tx_drain", tx_q.size(), 0);
    repeat (C) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, first;
    logic [1:0] r;
    int ok, i;
    do_reset();
    axi_write(4'h4, 32'hFFFF_FF41, 2, 1, r);
    chk("tx41_bresp", r, 2'b00);
    drain();
    chk("tx41_frame", m_frame, 10'b1010000010);
    axi_write(4'h8, 32'h12, 0, 0, r);
    chk("wr_status_bresp", r, 2'b10);
    axi_read(4'h4, d, r);
    chk("rd_tx_rresp", r, 2'b10);
    chk("rd_tx_rdata", d, 0);
    axi_read(4'hC, d, r);
    chk("rd_resv_rresp", r, 2'b10);
`ifdef UART_LOOPBACK_EN
    axi_read(4'h0, d, r);
    chk("lb_41", d, 32'h41);
    axi_write(4'h4, 32'hC3, 0, 0, r);
    drain();
    axi_read(4'h0, d, r);
    chk("lb_c3", d, 32'hC3);
    chk("lb_c3_rresp", r, 2'b00);
`else
    send_rx(8'h5A, 1'b1);
    axi_read(4'h8, d, r);
    chk("rx5a_status", d, 32'h5);
    axi_read(4'h0, d, r);
    chk("rx5a_data", d, 32'h5A);
    chk("rx5a_rresp", r, 2'b00);
    axi_read(4'h0, d, r);
    chk("rx_empty_rresp", r, 2'b10);
    chk("rx_empty_rdata", d, 0);
    rxd = 1'b0;
    repeat (C / 4) @(negedge clk);
    rxd = 1'b1;
    repeat (12 * C) @(negedge clk);
    axi_read(4'h8, d, r);
    chk("glitch_status", d, 32'h4);
    send_rx(8'hA5, 1'b0);
    repeat (C) @(negedge clk);
    axi_read(4'h8, d, r);
    chk("framing_status", d, 32'h4);
    for (int k = 0; k < 17; k++) send_rx(8'(k * 13 + 7), 1'b1);
    axi_read(4'h8, d, r);
    chk("ovf_status", d, 32'h7);
    first = '0;
    for (int k = 0; k < 17; k++) begin
      axi_read(4'h0, d, r);
      if (k == 0) first = d;
    end
    chk("ovf_first", first, 32'h7);
    chk("ovf_17th_rresp", r, 2'b10);
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0: if (tx_q.size() < 8) axi_write(4'h4, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), r);
        1: axi_write(4'($urandom_range(0, 3) * 4), $urandom, $urandom_range(0, 2), $urandom_range(0, 2), r);
        2: begin drain(); axi_read(4'h8, d, r); end
        3: send_rx(8'($urandom), $urandom_range(0, 4) != 0);
        default: axi_read(4'($urandom_range(0, 3) * 4), d, r);
      endcase
    end
    drain();
    while (rx_q.size() != 0) axi_read(4'h0, d, r);
    axi_read(4'h8, d, r);
    chk("rand_end_status", d, 32'h4);
`endif
    drain();
    ok = 0;
    for (int k = 0; k < 17; k++) begin
      axi_write(4'h4, 32'(8'h10 + k), 0, 0, r);
      if (r == 2'b00) ok++;
    end
    chk("burst_ok_count", ok, 16);
    chk("burst_17th_bresp", r, 2'b10);
    drain();
    axi_write(4'h4, 32'h33, 0, 0, r);
    @(negedge clk);
    awaddr = 4'h4;
    wdata = 32'h44;
    exp_bresp = 2'b00;
    tx_q.push_back(8'h44);
    awvalid = 1'b1;
    wvalid = 1'b1;
    b_pend = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    i = 0;
    while (!(m_act && m_t >= 4 * C + 2) && i < 1000) begin @(negedge clk); i++; end
    chk("bit4_reached", m_act, 1);
    rst = 1'b1;
    tx_q.delete();
    rx_q.delete();
    {r_pend, b_pend} = '0;
    @(negedge clk);
    chk("midframe_txd", txd, 1);
    chk("midframe_rvalid", rvalid, 0);
    chk("midframe_bvalid", bvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12 * C) @(negedge clk);
    axi_read(4'h8, d, r);
    chk("midframe_status", d, 32'h4);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_axi_lite.md
UART_AXI_LITE -- requirements
Module: uart_axi_lite

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clocks per serial bit (100 MHz / 115200).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, entries per RX and TX FIFO (power of two).
REQ-003 SHALL have port clk  in  1  sole clock; reset is synchronous and active-high.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports s_axi_araddr in 4, s_axi_arvalid in 1, s_axi_arready out 1: AXI4-Lite read address.
REQ-006 SHALL have ports s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1: read data.
REQ-007 SHALL have ports s_axi_awaddr in 4, s_axi_awvalid in 1, s_axi_awready out 1: write address.
REQ-008 SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4 (ignored), s_axi_wvalid in 1, s_axi_wready out 1: write data.
REQ-009 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1: write response.
REQ-010 SHALL have port rxd  in  1  serial input, idle high; port txd  out  1  serial output, idle high.

Function
REQ-011 Register map SHALL be: 0x0 RX data (read), 0x4 TX data (write), 0x8 status (read), 0xC reserved.
REQ-012 Read SM SHALL be R_IDLE -> R_RESP: arready=1 in R_IDLE; on arvalid it latches the address and the next cycle raises rvalid.
REQ-013 Status reads SHALL return {28'h0, tx_full, tx_empty, rx_full, rx_valid} with rresp=00.
REQ-014 An RX data read with a non-empty FIFO SHALL return {24'h0, byte} with rresp=00 and pop exactly one entry, at the handshake cycle.
REQ-015 An RX data read with an empty FIFO SHALL return rdata=0 and rresp=10 (SLVERR) and pop nothing.
REQ-016 rvalid SHALL hold, with rdata/rresp stable, until rready; the cycle after the handshake the SM returns to R_IDLE.
REQ-017 Write SM SHALL be W_IDLE -> W_RESP: awready and wready high in W_IDLE; address and data are accepted together only when awvalid and wvalid are both high.
REQ-018 A write to 0x4 with TX not full SHALL push wdata[7:0] with bresp=00; a full TX FIFO SHALL give bresp=10 and drop the byte.
REQ-019 Writes to any other address SHALL give bresp=10 with no side effect; reads of 0x4 or 0xC SHALL give rresp=10, rdata=0.
REQ-020 bvalid SHALL assert the cycle after acceptance and hold until bready; the response takes 1 cycle minimum.
REQ-021 TX SHALL send 8N1, LSB first: one start bit (0), 8 data bits, one stop bit (1), each CLKS_PER_BIT cycles, back-to-back while the FIFO is non-empty.
REQ-022 RX SHALL pass rxd through a 2-FF synchronizer, detect a falling edge and recheck low at mid-bit, then sample each data bit at mid-bit.
REQ-023 A start bit that reads high at mid-bit SHALL be discarded (glitch); a stop bit that reads 0 SHALL drop the byte (framing error).
REQ-024 An RX byte arriving at a full FIFO SHALL be dropped, with no existing entry overwritten.
REQ-025 FIFO pointers SHALL use log2(FIFO_DEPTH)+1 bits; full = MSBs differ and the rest are equal; push and pop in the same cycle SHALL both take effect.

Reset
REQ-026 When rst is high at a clk edge: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00, txd=1, both FIFOs empty, both SMs idle, baud counters 0.
REQ-027 Reset mid-frame SHALL abort TX immediately (txd=1 next cycle) and discard any partial RX byte and any pending AXI response.

Configuration
REQ-028 With UART_LOOPBACK_EN defined, the RX input SHALL be the internal txd and the rxd port is ignored; without it, RX uses rxd.

Verification
REQ-029 Write 0x4 data 0x41, bready=1 -> bresp=00; txd shows 0,1,0,0,0,0,0,1,0,1, each CLKS_PER_BIT cycles.
REQ-030 Drive 0x5A serially on rxd, then read 0x8 -> rdata=0x5 (tx_empty, rx_valid); read 0x0 -> 0x5A, rresp=00; read 0x0 again -> rresp=10.
REQ-031 17 back-to-back writes to 0x4 with baud stalled -> first 16 give bresp=00, the 17th gives bresp=10; 16 bytes are sent in order.
REQ-032 A rxd low pulse of CLKS_PER_BIT/4 cycles -> no byte received; a frame with stop bit 0 -> the FIFO stays empty.
REQ-033 UART_LOOPBACK_EN defined: write 0xC3 to 0x4, wait 10 bit times, read 0x0 -> 0xC3.
REQ-034 Assert rst during bit 4 of a TX frame -> txd=1 the next cycle, status=0x4, no rvalid or bvalid.
